// File: rtl/data_memory_responder.sv
// data_memory_responder: data-memory target with word RAM and an MMIO page (LED, SW, cycle timer, compare, fault capture)
module data_memory_responder #(
  parameter int          DEPTH   = 1024,
  parameter logic [31:0] IO_BASE = 32'h0000_8000,
  parameter int          LED_W   = 18
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      memory_address,
  input  logic [31:0]      memory_write_value,
  input  logic             memory_write_enable,
  output logic [31:0]      memory_read_value,
  input  logic [LED_W-1:0] SW,
  output logic [LED_W-1:0] LEDR,
  output logic             timer_match,
  output logic             fault
);
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);
  logic [31:0]      ram [DEPTH];
  logic [LED_W-1:0] led;
  logic [31:0]      cycle, compare, fault_addr;
  logic [1:0]       status;
  logic             in_ram, in_io, sel_led, sel_cycle, sel_compare, sel_status;
  logic             writable, wr_fault, match_hit;
  logic [3:0]       off;
  // address decode; misaligned addresses select nothing
  always_comb begin
    in_ram      = memory_address[1:0] == 2'b00 && memory_address < RAM_BYTES;
    in_io       = memory_address[1:0] == 2'b00 && memory_address[31:6] == IO_BASE[31:6];
    off         = memory_address[5:2];
    sel_led     = in_io && off == 4'd0;
    sel_cycle   = in_io && off == 4'd2;
    sel_compare = in_io && off == 4'd3;
    sel_status  = in_io && off == 4'd4;
    writable    = in_ram || sel_led || sel_cycle || sel_compare || sel_status;
    wr_fault    = memory_write_enable && !writable;
    match_hit   = compare != 32'd0 && cycle == compare;
  end
  // zero-latency read mux, no side effects
  always_comb
    memory_read_value = in_ram ? ram[memory_address[AW+1:2]] :
                        !in_io ? 32'd0 :
                        off == 4'd0 ? 32'(led) :
                        off == 4'd1 ? 32'(SW) :
                        off == 4'd2 ? cycle :
                        off == 4'd3 ? compare :
                        off == 4'd4 ? {30'd0, status} :
                        off == 4'd5 ? fault_addr : 32'd0;
  // word RAM, not cleared by reset
  always_ff @(posedge clock)
    if (memory_write_enable && in_ram) ram[memory_address[AW+1:2]] <= memory_write_value;
  // I/O registers; match/fault sets win over a same-cycle W1C
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      led        <= '0;
      cycle      <= '0;
      compare    <= '0;
      status     <= '0;
      fault_addr <= '0;
    end else begin
      cycle <= (memory_write_enable && sel_cycle) ? 32'd0 : cycle + 32'd1;
      if (memory_write_enable && sel_led) led <= memory_write_value[LED_W-1:0];
      if (memory_write_enable && sel_compare) compare <= memory_write_value;
      status[0] <= match_hit || (status[0] && !(memory_write_enable && sel_status && memory_write_value[0]));
      status[1] <= wr_fault || (status[1] && !(memory_write_enable && sel_status && memory_write_value[1]));
      if (wr_fault && !status[1]) fault_addr <= memory_address;
    end
  assign LEDR        = led;
  assign timer_match = status[0];
  assign fault       = status[1];
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: random + directed bench against a behavioural memory-map model
module tb_data_memory_responder;
  localparam int          DEPTH     = 1024;
  localparam logic [31:0] IO_BASE   = 32'h0000_8000;
  localparam int          LED_W     = 18;
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);
  localparam logic [31:0] A_LED = IO_BASE, A_SW = IO_BASE + 4, A_CYC = IO_BASE + 8;
  localparam logic [31:0] A_CMP = IO_BASE + 12, A_ST = IO_BASE + 16, A_FA = IO_BASE + 20;
  localparam logic [31:0] LED_MASK = (32'd1 << LED_W) - 32'd1;
  logic clock = 0, reset = 0;
  logic [31:0] memory_address = 0, memory_write_value = 0, memory_read_value;
  logic memory_write_enable = 0, timer_match, fault;
  logic [LED_W-1:0] SW = 0, LEDR;
  int pass_cnt = 0, total_cnt = 0;
  logic chk_en = 0;
  logic [31:0] m_ram [DEPTH];
  logic [31:0] m_led = 0, m_cycle = 0, m_cmp = 0, m_faddr = 0;
  logic m_match = 0, m_fault = 0;

  data_memory_responder #(.DEPTH(DEPTH), .IO_BASE(IO_BASE), .LED_W(LED_W)) dut (
    .clock(clock), .reset(reset), .memory_address(memory_address),
    .memory_write_value(memory_write_value), .memory_write_enable(memory_write_enable),
    .memory_read_value(memory_read_value), .SW(SW), .LEDR(LEDR),
    .timer_match(timer_match), .fault(fault));

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    else pass_cnt++;
  endtask

  function automatic logic [31:0] mread(input logic [31:0] a);
    if (a[1:0] != 2'b00) return 32'd0;
    if (a < RAM_BYTES) return m_ram[int'(a >> 2)];
    case (a)
      A_LED:   return m_led;
      A_SW:    return 32'(SW);
      A_CYC:   return m_cycle;
      A_CMP:   return m_cmp;
      A_ST:    return {30'd0, m_fault, m_match};
      A_FA:    return m_faddr;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clock or negedge reset) begin : model
    logic [31:0] a, w;
    logic e, ok, bad, clr0, clr1;
    if (!reset) begin
      m_led <= 0; m_cycle <= 0; m_cmp <= 0; m_faddr <= 0; m_match <= 0; m_fault <= 0;
    end else begin
      a = memory_address; w = memory_write_value; e = memory_write_enable;
      ok = a[1:0] == 2'b00 && (a < RAM_BYTES || a inside {A_LED, A_CYC, A_CMP, A_ST});
      bad = e && !ok;
      clr0 = e && a == A_ST && w[0];
      clr1 = e && a == A_ST && w[1];
      if (e && ok && a < RAM_BYTES) m_ram[int'(a >> 2)] <= w;
      if (e && a == A_LED) m_led <= w & LED_MASK;
      if (e && a == A_CMP) m_cmp <= w;
      m_cycle <= (e && a == A_CYC) ? 32'd0 : m_cycle + 32'd1;
      m_match <= (m_cmp != 0 && m_cycle == m_cmp) || (m_match && !clr0);
      m_fault <= bad || (m_fault && !clr1);
      if (bad && !m_fault) m_faddr <= a;
    end
  end

  always @(negedge clock)
    if (chk_en) begin
      check("read", memory_read_value, mread(memory_address));
      check("ledr", 32'(LEDR), m_led);
      check("timer_match", 32'(timer_match), 32'(m_match));
      check("fault", 32'(fault), 32'(m_fault));
    end

  task automatic drive(input logic [31:0] a, input logic [31:0] w, input logic e);
    memory_address = a; memory_write_value = w; memory_write_enable = e;
  endtask

  task automatic step;
    @(posedge clock); #1;
  endtask

  initial begin
    repeat (3) step;
    drive(A_CYC, 0, 0);
    #2 check("rst_ledr", 32'(LEDR), 0);
    check("rst_match", 32'(timer_match), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_cycle", memory_read_value, 0);
    reset = 1;
    for (int i = 0; i < 64; i++) begin drive(32'(i * 4), 32'h1000 + 32'(i), 1); step; end
    drive(RAM_BYTES - 4, 32'h1111, 1); step;
    chk_en = 1;
    drive(32'h10, 32'hDEADBEEF, 1);
    #2 check("ram_same_cycle_old", memory_read_value, 32'h1004);
    step; drive(32'h10, 0, 0);
    #2 check("ram_next_cycle_new", memory_read_value, 32'hDEADBEEF);
    step; drive(RAM_BYTES - 4, 32'hABCD0001, 1); step;
    drive(0, 32'h12345678, 1); step;
    drive(RAM_BYTES - 4, 0, 0);
    #2 check("ram_top", memory_read_value, 32'hABCD0001);
    step; drive(0, 0, 0);
    #2 check("ram_zero", memory_read_value, 32'h12345678);
    step; drive(A_LED, 32'hFFFFFFFF, 1); step;
    SW = 18'h00A5A; drive(A_SW, 0, 0);
    #2 check("ledr_all", 32'(LEDR), 32'h3FFFF);
    check("sw_read", memory_read_value, 32'h00000A5A);
    check("led_read", mread(A_LED), 32'h3FFFF);
    step; drive(A_CMP, 20, 1); step;
    drive(A_CYC, 0, 1); step;
    drive(A_CYC, 0, 0);
    for (int k = 0; k <= 20; k++) begin
      #2 check("tm_low", 32'(timer_match), 0);
      if (k < 2) check("cycle_after_clear", memory_read_value, 32'(k));
      step;
    end
    #2 check("tm_rise", 32'(timer_match), 1);
    step; drive(A_ST, 1, 1); step; drive(A_ST, 0, 0);
    #2 check("tm_w1c", 32'(timer_match), 0);
    check("status_read", memory_read_value, 0);
    step; drive(A_CYC, 0, 1); step; drive(A_ST, 0, 0);
    repeat (20) step;
    drive(A_ST, 1, 1); step; drive(A_ST, 0, 0);
    #2 check("set_beats_w1c", 32'(timer_match), 1);
    step; check("fault_clear_before", 32'(fault), 0);
    drive(32'h6, 32'h55, 1); step;
    drive(IO_BASE + 32'h40, 32'h77, 1); step;
    drive(A_FA, 0, 0);
    #2 check("fault_set", 32'(fault), 1);
    check("fault_addr_first", memory_read_value, 32'h6);
    step; drive(32'h4, 0, 0);
    #2 check("ram_unchanged", memory_read_value, 32'h1001);
    step; drive(A_ST, 2, 1); step; drive(A_ST, 0, 0);
    #2 check("fault_w1c", 32'(fault), 0);
    step;
    repeat (3000) begin
      logic [31:0] a, w;
      logic e;
      int r;
      r = $urandom_range(0, 9);
      w = $urandom;
      e = 1'($urandom);
      SW = LED_W'($urandom);
      case (r)
        0, 1, 2, 3: a = 32'(32 + $urandom_range(0, 31)) << 2;
        4: a = A_LED;
        5: begin a = A_SW; e = ($urandom_range(0, 3) == 0); end
        6: begin a = A_CYC; e = ($urandom_range(0, 7) == 0); end
        7: begin a = A_CMP; w = m_cycle + 32'($urandom_range(2, 12)); end
        8: begin a = A_ST; w = 32'($urandom_range(0, 3)); e = ($urandom_range(0, 3) == 0); end
        default: begin
          case ($urandom_range(0, 4))
            0: a = IO_BASE + 32'(4 * $urandom_range(6, 16));
            1: a = RAM_BYTES + 32'(4 * $urandom_range(0, 7));
            2: a = (32'(32 + $urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
            3: a = A_FA;
            default: a = $urandom | 32'h1000_0000;
          endcase
          e = ($urandom_range(0, 3) == 0);
        end
      endcase
      drive(a, w, e); step;
    end
    drive(A_LED, 3, 1); step;
    drive(A_SW, 0, 1); step;
    drive(A_LED, 5, 1);
    #2 reset = 0;
    #1 check("async_ledr", 32'(LEDR), 0);
    check("async_match", 32'(timer_match), 0);
    check("async_fault", 32'(fault), 0);
    drive(A_CYC, 0, 0);
    #1 check("async_cycle", memory_read_value, 0);
    drive(A_LED, 5, 1);
    step; step;
    drive(A_CYC, 0, 0);
    #2 reset = 1;
    step;
    #2 check("release_cycle", memory_read_value, 1);
    check("lost_write", 32'(LEDR), 0);
    step; drive(32'h10, 0, 0);
    #2 check("ram_keep_10", memory_read_value, 32'hDEADBEEF);
    step; drive(0, 0, 0);
    #2 check("ram_keep_0", memory_read_value, 32'h12345678);
    step;
    chk_en = 0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
